// File: rtl/uart_debug_loader_pkg.sv
// Shared encodings and helpers for the UART debug loader.
// Optional checksum stage is enabled by defining UART_LOADER_CHKSUM_EN (off by default).
package uart_debug_loader_pkg;

  // Receiver state encoding
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Loader state encoding; L_CHK only exists with the checksum stage
`ifdef UART_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_LEN  = 3'd1,
    L_DATA = 3'd2,
    L_CHK  = 3'd3,
    L_DONE = 3'd4
  } ld_state_e;
`else
  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_LEN  = 3'd1,
    L_DATA = 3'd2,
    L_DONE = 3'd4
  } ld_state_e;
`endif

  // Clock cycles per UART bit (floor)
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_debug_loader_uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser plus oversampling-free bit FSM.
module uart_rx_core
  import uart_debug_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  logic [1:0]       r_sync;
  logic             r_prev;
  logic             w_rx;
  logic             w_fall;
  rx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_brk;

  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;

  // Synchronise rxd and keep the previous synced value for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
      r_prev <= r_sync[1];
    end
  end

  // Bit-level receive FSM; samples mid-bit, LSB first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_brk        <= 1'b0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // After a bad stop bit, park here until the line returns high
          if (r_brk) begin
            if (w_rx) begin
              r_brk   <= 1'b0;
              r_state <= RX_IDLE;
            end
          end else if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (w_rx) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
              r_state      <= RX_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              r_brk       <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_debug_loader.sv
// Length-prefixed UART program loader writing DATA_W words into the instruction ROM.
// Define UART_LOADER_CHKSUM_EN to add a trailing 8-bit checksum byte check.
module uart_debug_loader
  import uart_debug_loader_pkg::*;
#(
  parameter int unsigned       CLK_FREQ  = 50_000_000,
  parameter int unsigned       BAUD      = 115200,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug,
  input  logic              uart_rxd,
  output logic              ce_o,
  output logic              wen_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              hold_o,
  output logic              done_o,
  output logic              frame_err_o,
  output logic              chk_err_o,
  output logic [15:0]       word_cnt_o
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_B = BIDX_W'(BYTES - 1);

  logic              [7:0] w_byte;
  logic                    w_byte_valid;
  logic                    w_frame_err;
  ld_state_e               r_state;
  logic                    r_debug_q;
  logic             [15:0] r_len;
  logic       [BIDX_W-1:0] r_bidx;
  logic             [15:0] r_widx;
  logic       [DATA_W-1:0] r_word;
  logic       [DATA_W+7:0] w_cat;
  logic       [DATA_W-1:0] w_word_next;
  logic             [31:0] w_widx_mod;
  logic       [ADDR_W-1:0] w_addr;
  logic             [15:0] w_widx_inc;
`ifdef UART_LOADER_CHKSUM_EN
  logic              [7:0] r_sum;
`endif

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_rxd        (uart_rxd),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  // New bytes enter at the top so the first byte ends up in the LSBs
  assign w_cat       = {w_byte, r_word};
  assign w_word_next = w_cat[DATA_W+7:8];
  assign w_widx_mod  = 32'(r_widx) & 32'(DEPTH - 1);
  assign w_addr      = BASE_ADDR + ADDR_W'(w_widx_mod * BYTES);
  assign w_widx_inc  = r_widx + 16'd1;
  assign hold_o      = ce_o;

`ifndef UART_LOADER_CHKSUM_EN
  assign chk_err_o = 1'b0;
`endif

  // Loader FSM: length header, word assembly, write strobes, completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= L_IDLE;
      r_debug_q   <= 1'b0;
      r_len       <= '0;
      r_bidx      <= '0;
      r_widx      <= '0;
      r_word      <= '0;
      ce_o        <= 1'b0;
      wen_o       <= 1'b0;
      addr_o      <= BASE_ADDR;
      data_o      <= '0;
      done_o      <= 1'b0;
      frame_err_o <= 1'b0;
      word_cnt_o  <= '0;
`ifdef UART_LOADER_CHKSUM_EN
      r_sum       <= '0;
      chk_err_o   <= 1'b0;
`endif
    end else begin
      r_debug_q <= debug;
      wen_o     <= 1'b0;
      if (w_frame_err) frame_err_o <= 1'b1;

      // Debug low aborts any load; the abort beats a coincident byte
      if (!debug && (r_state != L_IDLE)) begin
        r_state <= L_IDLE;
        ce_o    <= 1'b0;
        done_o  <= 1'b0;
      end else begin
        case (r_state)
          L_IDLE: begin
            if (debug && !r_debug_q) begin
              r_state     <= L_LEN;
              ce_o        <= 1'b1;
              frame_err_o <= 1'b0;
              word_cnt_o  <= '0;
              r_bidx      <= '0;
              r_widx      <= '0;
              r_len       <= '0;
              addr_o      <= BASE_ADDR;
`ifdef UART_LOADER_CHKSUM_EN
              r_sum       <= '0;
              chk_err_o   <= 1'b0;
`endif
            end
          end
          L_LEN: begin
            if (w_byte_valid) begin
              if (r_bidx == '0) begin
                r_len[7:0] <= w_byte;
                r_bidx     <= BIDX_W'(1);
              end else begin
                r_len[15:8] <= w_byte;
                r_bidx      <= '0;
                if ({w_byte, r_len[7:0]} == 16'd0) begin
`ifdef UART_LOADER_CHKSUM_EN
                  r_state <= L_CHK;
`else
                  r_state <= L_DONE;
                  done_o  <= 1'b1;
                  ce_o    <= 1'b0;
`endif
                end else begin
                  r_state <= L_DATA;
                end
              end
            end
          end
          L_DATA: begin
            if (w_byte_valid) begin
              r_word <= w_word_next;
`ifdef UART_LOADER_CHKSUM_EN
              r_sum  <= r_sum + w_byte;
`endif
              if (r_bidx == LAST_B) begin
                r_bidx     <= '0;
                wen_o      <= 1'b1;
                data_o     <= w_word_next;
                addr_o     <= w_addr;
                word_cnt_o <= w_widx_inc;
                r_widx     <= w_widx_inc;
                if (w_widx_inc == r_len) begin
`ifdef UART_LOADER_CHKSUM_EN
                  r_state <= L_CHK;
`else
                  r_state <= L_DONE;
                  done_o  <= 1'b1;
                  ce_o    <= 1'b0;
`endif
                end
              end else begin
                r_bidx <= r_bidx + 1'b1;
              end
            end
          end
`ifdef UART_LOADER_CHKSUM_EN
          L_CHK: begin
            if (w_byte_valid) begin
              r_state <= L_DONE;
              ce_o    <= 1'b0;
              if (w_byte == r_sum) done_o    <= 1'b1;
              else                 chk_err_o <= 1'b1;
            end
          end
`endif
          L_DONE: begin
            ce_o <= 1'b0;
          end
          default: r_state <= L_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_debug_loader.sv
// Directed testbench for uart_debug_loader (DIV = 10, DEPTH = 4).
module tb_uart_debug_loader;

  localparam int unsigned DIV = 10;
`ifdef UART_LOADER_CHKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        debug = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        ce_o, wen_o, hold_o, done_o, frame_err_o, chk_err_o;
  logic [31:0] addr_o, data_o;
  logic [15:0] word_cnt_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bv_cyc = -10;
  int done_rise_cyc = -20;
  logic done_q = 1'b0;
  logic [31:0] wa [16];
  logic [31:0] wd [16];
  int nw = 0;

  uart_debug_loader #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (5_000_000),
    .DATA_W    (32),
    .ADDR_W    (32),
    .DEPTH     (4),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .debug       (debug),
    .uart_rxd    (uart_rxd),
    .ce_o        (ce_o),
    .wen_o       (wen_o),
    .addr_o      (addr_o),
    .data_o      (data_o),
    .hold_o      (hold_o),
    .done_o      (done_o),
    .frame_err_o (frame_err_o),
    .chk_err_o   (chk_err_o),
    .word_cnt_o  (word_cnt_o)
  );

  always #5 clk = ~clk;

  // Record write strobes and timing references away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dut.w_byte_valid) bv_cyc = cyc;
    if (done_o && !done_q) done_rise_cyc = cyc;
    done_q = done_o;
    if (wen_o) begin
      if (nw < 16) begin
        wa[nw] = addr_o;
        wd[nw] = data_o;
      end
      nw = nw + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(DIV);
    end
    uart_rxd = stop_bit;
    tick(DIV);
    uart_rxd = 1'b1;
    tick(4);
  endtask

  task automatic send_chk(input logic [7:0] s);
    if (CHK_ON) send_byte(s, 1'b1);
  endtask

  task automatic begin_load();
    debug = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) begin
      wa[i] = 32'hDEAD_BEEF;
      wd[i] = 32'hDEAD_BEEF;
    end
    nw = 0;
    debug = 1'b1;
    tick(2);
  endtask

  task automatic end_load();
    debug = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    tests++;
    if ({ce_o, wen_o, hold_o, done_o, frame_err_o, chk_err_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got %b exp 000000",
               {ce_o, wen_o, hold_o, done_o, frame_err_o, chk_err_o});
    end
    tests++;
    if (addr_o !== 32'h0 || data_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr_data got %h/%h exp 0/0", addr_o, data_o);
    end
    tests++;
    if (word_cnt_o !== 16'd0) begin
      fails++;
      $display("FAIL reset_cnt got %0d exp 0", word_cnt_o);
    end
    rst = 1'b1;
    tick(3);
  endtask

  task automatic test_basic_load();
    begin_load();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    tests++;
    if (ce_o !== 1'b1 || hold_o !== 1'b1) begin
      fails++;
      $display("FAIL basic_ce_during got ce=%b hold=%b exp 1/1", ce_o, hold_o);
    end
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    send_chk(8'hB6);
    tick(2);
    tests++;
    if (nw !== 2) begin
      fails++;
      $display("FAIL basic_nwrites got %0d exp 2", nw);
    end
    tests++;
    if (wa[0] !== 32'h0 || wd[0] !== 32'h0000_0013) begin
      fails++;
      $display("FAIL basic_w0 got %h:%h exp 00000000:00000013", wa[0], wd[0]);
    end
    tests++;
    if (wa[1] !== 32'h4 || wd[1] !== 32'h0010_0093) begin
      fails++;
      $display("FAIL basic_w1 got %h:%h exp 00000004:00100093", wa[1], wd[1]);
    end
    tests++;
    if (done_o !== 1'b1 || word_cnt_o !== 16'd2 || ce_o !== 1'b0 || hold_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_done got done=%b cnt=%0d ce=%b hold=%b exp 1/2/0/0",
               done_o, word_cnt_o, ce_o, hold_o);
    end
    end_load();
    tests++;
    if (done_o !== 1'b0 || word_cnt_o !== 16'd2) begin
      fails++;
      $display("FAIL basic_after_debug got done=%b cnt=%0d exp 0/2", done_o, word_cnt_o);
    end
  endtask

  task automatic test_zero_len();
    begin_load();
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_chk(8'h00);
    tests++;
    if (nw !== 0 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL zero_len got writes=%0d done=%b exp 0/1", nw, done_o);
    end
    tests++;
    if (done_rise_cyc !== bv_cyc + 1) begin
      fails++;
      $display("FAIL zero_len_latency got %0d exp %0d", done_rise_cyc - bv_cyc, 1);
    end
    end_load();
  endtask

  task automatic test_frame_err();
    begin_load();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b0);
    tests++;
    if (frame_err_o !== 1'b1) begin
      fails++;
      $display("FAIL frame_err_set got %b exp 1", frame_err_o);
    end
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    send_chk(8'h0E);
    tests++;
    if (nw !== 1 || wd[0] !== 32'hDDCC_BBAA || done_o !== 1'b1 || frame_err_o !== 1'b1) begin
      fails++;
      $display("FAIL frame_err_drop got n=%0d d=%h done=%b fe=%b exp 1/ddccbbaa/1/1",
               nw, wd[0], done_o, frame_err_o);
    end
    end_load();
    // Short low glitch must produce neither a byte nor an error
    begin_load();
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(3 * DIV);
    tests++;
    if (frame_err_o !== 1'b0) begin
      fails++;
      $display("FAIL glitch_no_err got %b exp 0", frame_err_o);
    end
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    send_chk(8'hAA);
    tests++;
    if (nw !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'h4433_2211 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL glitch_load got n=%0d a=%h d=%h done=%b exp 1/0/44332211/1",
               nw, wa[0], wd[0], done_o);
    end
    end_load();
  endtask

  task automatic test_abort();
    begin_load();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    tests++;
    if (ce_o !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre_ce got %b exp 1", ce_o);
    end
    debug = 1'b0;
    tick(1);
    tests++;
    if (ce_o !== 1'b0 || hold_o !== 1'b0) begin
      fails++;
      $display("FAIL abort_ce got ce=%b hold=%b exp 0/0", ce_o, hold_o);
    end
    tick(3);
    tests++;
    if (nw !== 0) begin
      fails++;
      $display("FAIL abort_no_write got %0d exp 0", nw);
    end
    begin_load();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    send_chk(8'h38);
    tests++;
    if (nw !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'hEFBE_ADDE || done_o !== 1'b1) begin
      fails++;
      $display("FAIL abort_reload got n=%0d a=%h d=%h done=%b exp 1/0/efbeadde/1",
               nw, wa[0], wd[0], done_o);
    end
    end_load();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [5];
    exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8;
    exp_a[3] = 32'hC; exp_a[4] = 32'h0;
    begin_load();
    send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k), 1'b1);
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    end
    send_chk(8'h0F);
    tests++;
    if (nw !== 5 || word_cnt_o !== 16'd5 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL wrap_count got n=%0d cnt=%0d done=%b exp 5/5/1", nw, word_cnt_o, done_o);
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (wa[k] !== exp_a[k] || wd[k] !== 32'(k + 1)) begin
        fails++;
        $display("FAIL wrap_w%0d got %h:%h exp %h:%h", k, wa[k], wd[k], exp_a[k], 32'(k + 1));
      end
    end
    end_load();
  endtask

  task automatic test_reset_mid();
    begin_load();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    uart_rxd = 1'b0;
    tick(DIV + 3);
    tests++;
    if (ce_o !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre_ce got %b exp 1", ce_o);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({ce_o, wen_o, hold_o, done_o, frame_err_o, chk_err_o} !== 6'b0 ||
        addr_o !== 32'h0 || data_o !== 32'h0 || word_cnt_o !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_outputs got flags=%b a=%h d=%h cnt=%0d exp 0/0/0/0",
               {ce_o, wen_o, hold_o, done_o, frame_err_o, chk_err_o}, addr_o, data_o, word_cnt_o);
    end
    uart_rxd = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2 * DIV);
    end_load();
  endtask

`ifdef UART_LOADER_CHKSUM_EN
  task automatic test_chksum();
    begin_load();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h0A, 1'b1);
    tests++;
    if (done_o !== 1'b1 || chk_err_o !== 1'b0 || nw !== 1 || wd[0] !== 32'h0403_0201) begin
      fails++;
      $display("FAIL chk_good got done=%b err=%b n=%0d d=%h exp 1/0/1/04030201",
               done_o, chk_err_o, nw, wd[0]);
    end
    end_load();
    begin_load();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h0B, 1'b1);
    tests++;
    if (done_o !== 1'b0 || chk_err_o !== 1'b1 || ce_o !== 1'b0) begin
      fails++;
      $display("FAIL chk_bad got done=%b err=%b ce=%b exp 0/1/0", done_o, chk_err_o, ce_o);
    end
    end_load();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_zero_len();
    test_frame_err();
    test_abort();
    test_wrap();
    test_reset_mid();
`ifdef UART_LOADER_CHKSUM_EN
    test_chksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_debug_loader.md
Name: uart_debug_loader

Overview:
- Parametrised UART program loader: receives a length-prefixed byte stream on uart_rxd while debug is high.
- Assembles bytes into DATA_W-bit words and issues single-cycle write strobes into the instruction ROM's write port.
- Holds the core in stall for the whole load.
- Sits between the SoC uart_rxd pin and the ROM write port (ce/wen/addr/data), replacing the fixed-width debug path with configurable baud, word width, depth and base address.

Parameters:
CLK_FREQ  50_000_000  system clock frequency, Hz
BAUD  115200  UART bit rate; DIV = CLK_FREQ/BAUD, floor, must be >= 4
DATA_W  32  word width written to memory; multiple of 8, range 8..64
ADDR_W  32  address output width
DEPTH  4096  memory depth in words, power of two; word index wraps modulo DEPTH
BASE_ADDR  0  byte address of word 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
debug  in  1  load enable, level sensitive
uart_rxd  in  1  UART receive line, idle high, 8N1
ce_o  out  1  memory chip enable, high while loading
wen_o  out  1  one-cycle write strobe per assembled word
addr_o  out  ADDR_W  byte write address
data_o  out  DATA_W  write data
hold_o  out  1  core stall request, equal to ce_o
done_o  out  1  load completed, held until debug falls
frame_err_o  out  1  sticky stop-bit error
chk_err_o  out  1  sticky checksum error; tied 0 without the optional feature
word_cnt_o  out  16  words written in the current load

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, also mid-load): ce_o/wen_o/hold_o/done_o/frame_err_o/chk_err_o = 0, addr_o = BASE_ADDR, data_o = 0, word_cnt_o = 0, both FSMs to idle.
- rxd synchroniser: 2 flops, reset to 1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synced falling edge.
  - START waits DIV/2 cycles, then re-samples: low -> DATA; high -> IDLE (glitch, no byte).
  - DATA samples 8 bits every DIV cycles, LSB first.
  - STOP samples at DIV:
    - high: byte_valid pulses 1 cycle.
    - low: frame_err_o set, byte dropped, FSM waits for rxd high, then IDLE.
- Loader FSM states: L_IDLE, L_LEN, L_DATA, (L_CHK), L_DONE.
  - L_IDLE -> L_LEN on debug rising.
  - Entering L_LEN clears frame_err_o, chk_err_o, word_cnt_o, byte/word index; addr_o = BASE_ADDR.
  - L_LEN takes 2 bytes, little-endian, as N words.
    - N == 0: go to L_DONE (or L_CHK when enabled) on the cycle after the 2nd byte_valid.
    - Otherwise: go to L_DATA.
  - L_DATA shifts bytes LSB-first into a DATA_W word.
    - On the cycle after the byte_valid completing DATA_W/8 bytes: wen_o=1 for exactly 1 cycle.
    - At the same time: data_o = word, addr_o = BASE_ADDR + (idx mod DEPTH)*(DATA_W/8), word_cnt_o = idx+1, idx increments.
    - When idx reaches N: go to L_DONE (or L_CHK).
    - Index wrap: word DEPTH writes word 0's address again.
  - L_DONE: done_o=1, ce_o=hold_o=0; further bytes ignored.
- ce_o = hold_o = 1 exactly in L_LEN, L_DATA, L_CHK.
- Debug falling in any state: loader returns to L_IDLE next cycle.
  - Partial word discarded, no wen_o, done_o cleared; word_cnt_o and error flags keep their values.
  - RX FSM keeps running; bytes received outside L_LEN/L_DATA/L_CHK are discarded.
- Debug falling and byte_valid in the same cycle: abort wins, no write.

Optional Feature:
- UART_LOADER_CHKSUM_EN defined:
  - After the N words, state L_CHK expects 1 byte = 8-bit sum, mod 256, of all data bytes (length bytes excluded).
  - Match: L_DONE with done_o=1.
  - Mismatch: chk_err_o=1 and L_DONE with done_o=0.
- Undefined: no L_CHK state, no sum register, chk_err_o constant 0.

Decomposition:
- Shared include header holds:
  - RX and loader state encodings;
  - the DIV computation macro;
  - the UART_LOADER_CHKSUM_EN default (off).
- One sub-module, uart_rx_core: synchroniser plus RX FSM, emitting byte and byte_valid plus a frame-error pulse.
- uart_debug_loader holds the loader FSM, assembly and address generation.

Test Plan:
- CLK_FREQ=50_000_000, BAUD=5_000_000 (DIV=10); debug=1, send 02 00 13 00 00 00 93 00 10 00 -> wen_o at addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; done_o=1, word_cnt_o=2, ce_o=0 after.
- Length 00 00 -> no wen_o, done_o=1 one cycle after 2nd byte.
- Data byte with stop bit 0 -> frame_err_o=1, byte dropped; separately, a rxd low pulse of 3 cycles -> no byte, no error.
- debug drops after 2 of 4 word bytes -> no wen_o, ce_o=0 next cycle; re-raise and send a full 1-word load -> write at BASE_ADDR.
- DEPTH=4, N=5 -> 5th write at addr 0x0; rst pulsed low mid-byte -> all outputs at reset values immediately.
- With UART_LOADER_CHKSUM_EN: 1 word 01 02 03 04, checksum 0x0A -> done_o=1; checksum 0x0B -> chk_err_o=1, done_o=0.
